// File: rtl/fp_accumulator.sv
// fp_accumulator
//
// Sums a stream of floating-point products coming out of the combinational
// multiplier. One product is taken per in_valid/in_ready handshake and is
// added into a running sum through a multi-cycle align / add / normalise /
// round sequence. When the product tagged in_last has been absorbed, the sum
// is presented on the out_valid/out_ready port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. Data and flags must be stable while valid is high and
// ready is low. Valid never depends on ready in the same cycle.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  product handshake
//   in_data            product {sign, exp, frac}
//   in_exception/overflow/underflow  multiplier flags for in_data
//   in_last            this product closes the current sum
//   out_valid/out_ready  sum handshake
//   out_data           accumulated sum (0 when the exception flag is set)
//   out_exception/overflow/underflow  sticky flags of the completed sum
//   dbg_state          current FSM state, for checkers
module fp_accumulator #(
    parameter int frac_bits = 23,
    parameter int exp_bits  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [exp_bits+frac_bits:0] in_data,
    input  logic                        in_exception,
    input  logic                        in_overflow,
    input  logic                        in_underflow,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [exp_bits+frac_bits:0] out_data,
    output logic                        out_exception,
    output logic                        out_overflow,
    output logic                        out_underflow,
    output logic [2:0]                  dbg_state
);

    localparam int W  = exp_bits + frac_bits + 1;
    // hidden one + fraction + guard, round, sticky
    localparam int MW = frac_bits + 4;
    // one spare bit so exponent over/underflow checks cannot wrap
    localparam int EW = exp_bits + 1;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {exp_bits{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t state, state_nxt, done_state;

    logic [W-1:0]  acc;
    logic [W-1:0]  op_r;
    logic          exc, ovf, unf, last_r;
    logic          a_sign, sub_r;
    logic [EW-1:0] e_r;
    logic [MW-1:0] a_man, b_man;
    logic [MW:0]   m_r;             // carry bit on top

    logic accept, skip;

    // ---------------- align: order operands, shift the smaller ----------
    logic [W-1:0]        a_word, b_word;
    logic [exp_bits-1:0] ea, eb, diff;
    logic                sa, sb;
    logic [MW-1:0]       ma_ext, mb_ext, mb_sh, lost;

    always_comb begin
        // Larger magnitude goes to A; {exp, frac} compares exponent first
        // and mantissa on a tie.
        if (op_r[W-2:0] > acc[W-2:0]) begin
            a_word = op_r;
            b_word = acc;
        end else begin
            a_word = acc;
            b_word = op_r;
        end
        sa     = a_word[W-1];
        sb     = b_word[W-1];
        ea     = a_word[W-2:frac_bits];
        eb     = b_word[W-2:frac_bits];
        // Exponent 0 is zero, so the hidden bit is absent.
        ma_ext = {(ea != '0), a_word[frac_bits-1:0], 3'b000};
        mb_ext = {(eb != '0), b_word[frac_bits-1:0], 3'b000};
        diff   = ea - eb;
        lost   = mb_ext & ~({MW{1'b1}} << diff);
        if (diff > exp_bits'(MW-1)) begin
            // B lies entirely below the sticky position.
            mb_sh = {{(MW-1){1'b0}}, |mb_ext};
        end else begin
            mb_sh = (mb_ext >> diff) | {{(MW-1){1'b0}}, |lost};
        end
    end

    // ---------------- round: nearest, ties to even ----------------------
    logic [frac_bits:0]   r_mant;
    logic                 r_up, r_ovf;
    logic [frac_bits+1:0] r_sum;
    logic [EW-1:0]        r_exp;
    logic [frac_bits-1:0] r_frac;

    always_comb begin
        r_mant = m_r[MW-1:3];
        // guard set and (round | sticky | odd lsb)
        r_up   = m_r[2] & (m_r[1] | m_r[0] | m_r[3]);
        r_sum  = {1'b0, r_mant} + {{(frac_bits+1){1'b0}}, r_up};
        if (r_sum[frac_bits+1]) begin
            r_exp  = e_r + EW'(1);
            r_frac = r_sum[frac_bits:1];
        end else begin
            r_exp  = e_r;
            r_frac = r_sum[frac_bits-1:0];
        end
        r_ovf = (r_exp >= EXP_MAX);
    end

    // ---------------- control -------------------------------------------
    assign in_ready = rst_n && (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign skip     = in_exception || in_overflow || in_underflow ||
                      (in_data[W-2:frac_bits] == '0) || exc || ovf;

    always_comb begin
        done_state = last_r ? S_OUT : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (skip) state_nxt = in_last ? S_OUT : S_IDLE;
                    else      state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM: begin
                if (m_r[MW])               state_nxt = S_ROUND;
                else if (m_r == '0)        state_nxt = done_state;
                else if (m_r[MW-1])        state_nxt = S_ROUND;
                else if (e_r == EW'(1))    state_nxt = done_state;
                // This cycle's left shift brings the leading one to the top.
                else if (m_r[MW-2])        state_nxt = S_ROUND;
                else                       state_nxt = S_NORM;
            end
            S_ROUND: state_nxt = done_state;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath ------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            op_r   <= '0;
            exc    <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            last_r <= 1'b0;
            a_sign <= 1'b0;
            sub_r  <= 1'b0;
            e_r    <= '0;
            a_man  <= '0;
            b_man  <= '0;
            m_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r   <= in_data;
                        last_r <= in_last;
                        if (in_exception) exc <= 1'b1;
                        if (in_underflow) unf <= 1'b1;
                        if (in_overflow) begin
                            ovf <= 1'b1;
                            acc <= {in_data[W-1], {exp_bits{1'b1}}, {frac_bits{1'b0}}};
                        end
                    end
                end
                S_ALIGN: begin
                    a_sign <= sa;
                    sub_r  <= sa ^ sb;
                    e_r    <= {1'b0, ea};
                    a_man  <= ma_ext;
                    b_man  <= mb_sh;
                end
                S_ADD: begin
                    // A >= B in magnitude, so the difference is never negative.
                    if (sub_r) m_r <= {1'b0, a_man} - {1'b0, b_man};
                    else       m_r <= {1'b0, a_man} + {1'b0, b_man};
                end
                S_NORM: begin
                    if (m_r[MW]) begin
                        // keep the dropped bit alive in sticky
                        m_r <= {1'b0, m_r[MW:2], m_r[1] | m_r[0]};
                        e_r <= e_r + EW'(1);
                    end else if (m_r == '0) begin
                        acc <= '0;
                    end else if (!m_r[MW-1]) begin
                        m_r <= m_r << 1;
                        e_r <= e_r - EW'(1);
                        if (e_r == EW'(1)) begin
                            acc <= '0;
                            unf <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    if (r_ovf) begin
                        acc <= {a_sign, {exp_bits{1'b1}}, {frac_bits{1'b0}}};
                        ovf <= 1'b1;
                    end else begin
                        acc <= {a_sign, r_exp[exp_bits-1:0], r_frac};
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc <= '0;
                        exc <= 1'b0;
                        ovf <= 1'b0;
                        unf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs -------------------------------------------
    assign out_valid     = (state == S_OUT);
    // An exception forces a zero result, as the multiplier does.
    assign out_data      = (out_valid && !exc) ? acc : '0;
    assign out_exception = out_valid && exc;
    assign out_overflow  = out_valid && ovf;
    assign out_underflow = out_valid && unf;
    assign dbg_state     = state;

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: directed scenarios plus random streams checked
// against an exact-arithmetic model of the accumulation.
module tb_fp_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        in_exception, in_overflow, in_underflow, in_last;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_exception, out_overflow, out_underflow;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // expected {exception, overflow, underflow, data}
    logic [34:0] exp_q[$];
    logic [31:0] st_d[$];
    logic [2:0]  st_f[$];

    always #5 clk = ~clk;

    fp_accumulator dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_exception(in_exception), .in_overflow(in_overflow),
        .in_underflow(in_underflow), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exception(out_exception), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .dbg_state(dbg_state)
    );

    // ---------------- reference model -----------------------------------
    // Exact sum on wide integers, then flush / round-to-nearest-even /
    // saturate to infinity.
    function automatic void fp_add_model(input logic [31:0] a, input logic [31:0] b,
                                         output logic [31:0] r, output bit unf_o,
                                         output bit ovf_o);
        logic [300:0] va, vb, mag, keep, rem, half;
        int ea, eb, lo, p, e, sh;
        bit sgn;
        unf_o = 0;
        ovf_o = 0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0) begin r = (eb == 0) ? 32'h0 : b; return; end
        if (eb == 0) begin r = a; return; end
        lo = (ea < eb) ? ea : eb;
        va = 301'({1'b1, a[22:0]}) << (ea - lo);
        vb = 301'({1'b1, b[22:0]}) << (eb - lo);
        if (a[31] == b[31]) begin mag = va + vb; sgn = a[31]; end
        else if (va >= vb)  begin mag = va - vb; sgn = a[31]; end
        else                begin mag = vb - va; sgn = b[31]; end
        if (mag == 0) begin r = 32'h0; return; end
        p = 0;
        for (int i = 0; i < 301; i++) if (mag[i]) p = i;
        e = lo + p - 23;
        if (e <= 0) begin r = 32'h0; unf_o = 1; return; end
        if (p > 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag & ((301'd1 << sh) - 301'd1);
            half = 301'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 301'd1;
            if (keep[24]) begin keep = keep >> 1; e = e + 1; end
        end else begin
            keep = mag << (23 - p);
        end
        if (e >= 255) begin r = {sgn, 8'hff, 23'h0}; ovf_o = 1; return; end
        r = {sgn, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [34:0] model_stream();
        logic [31:0] acc, r;
        bit exc, ovf, unf, u, o;
        acc = 0; exc = 0; ovf = 0; unf = 0;
        foreach (st_d[i]) begin
            if (st_f[i][2]) exc = 1;
            if (st_f[i][1]) begin ovf = 1; acc = {st_d[i][31], 8'hff, 23'h0}; end
            if (st_f[i][0]) unf = 1;
            if (st_f[i] == 3'b000 && st_d[i][30:23] != 8'h00 && !exc && !ovf) begin
                fp_add_model(acc, st_d[i], r, u, o);
                acc = r;
                if (u) unf = 1;
                if (o) ovf = 1;
            end
        end
        return {exc, ovf, unf, exc ? 32'h0 : acc};
    endfunction

    // ---------------- driver tasks --------------------------------------
    task automatic send_op(input logic [31:0] d, input logic [2:0] f, input logic last);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        {in_exception, in_overflow, in_underflow} = f;
        in_last  = last;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        {in_exception, in_overflow, in_underflow} = 3'b000;
    endtask

    // cycles with in_ready low, starting the cycle after an accept
    task automatic count_ready_low(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    // cycles until out_valid, noting whether in_ready was ever high
    task automatic count_valid_wait(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin
            if (in_ready) rdy_seen = 1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic collect_output(input string name, input int hold);
        logic [34:0] got, exp_v, first;
        int waited;
        waited = 0;
        while (!out_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid=%b, required 1", name, out_valid);
            return;
        end
        exp_v = exp_q.pop_front();
        got = {out_exception, out_overflow, out_underflow, out_data};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got flags/data %h, required %h", name, got, exp_v);
        end
        first = got;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            got = {out_exception, out_overflow, out_underflow, out_data};
            checks++;
            if (out_valid !== 1'b1 || got !== first) begin
                errors++;
                $display("FAIL %s_hold: valid=%b data %h, required 1 and %h", name, out_valid, got, first);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 and 1", name, out_valid, in_ready);
        end
    endtask

    task automatic push_op(input logic [31:0] d, input logic [2:0] f);
        st_d.push_back(d);
        st_f.push_back(f);
    endtask

    // Expected value comes from the model when use_model is set, else from req.
    task automatic run_stream(input string name, input bit use_model, input logic [34:0] req,
                              input int hold);
        exp_q.push_back(use_model ? model_stream() : req);
        foreach (st_d[i]) send_op(st_d[i], st_f[i], i == st_d.size() - 1);
        collect_output(name, hold);
        st_d.delete();
        st_f.delete();
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // ---------------- scenarios -----------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        checks++;
        if ({out_valid, out_exception, out_overflow, out_underflow, out_data} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {out_valid, out_exception, out_overflow, out_underflow, out_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_simple_sum();
        int n;
        bit rdy;
        exp_q.push_back({3'b000, 32'h40700000});
        send_op(32'h3FC00000, 3'b000, 1'b0);
        count_ready_low(n);
        check_int("simple_ready_low", n, 4);
        send_op(32'h40100000, 3'b000, 1'b1);
        count_valid_wait(n, rdy);
        check_int("simple_out_latency", n, 4);
        check_int("simple_ready_during_add", int'(rdy), 0);
        collect_output("simple_sum", 0);
    endtask

    task automatic test_cancel();
        int n;
        bit rdy;
        push_op(32'h3F800000, 3'b000);
        push_op(32'hBF800000, 3'b000);
        run_stream("cancel_zero", 0, {3'b000, 32'h00000000}, 0);
        exp_q.push_back({3'b000, 32'h34000000});
        send_op(32'h3F800001, 3'b000, 1'b0);
        count_ready_low(n);
        send_op(32'hBF800000, 3'b000, 1'b1);
        count_valid_wait(n, rdy);
        // ALIGN + ADD + 23 NORM + ROUND
        check_int("long_norm_latency", n, 26);
        check_int("long_norm_ready", int'(rdy), 0);
        collect_output("long_norm", 0);
    endtask

    task automatic test_rounding();
        push_op(32'h3F800000, 3'b000);
        push_op(32'h33800000, 3'b000);
        run_stream("tie_even_down", 0, {3'b000, 32'h3F800000}, 1);
        push_op(32'h3F800001, 3'b000);
        push_op(32'h33800000, 3'b000);
        run_stream("tie_odd_up", 0, {3'b000, 32'h3F800002}, 0);
    endtask

    task automatic test_flags();
        int n;
        push_op(32'h7F7FFFFF, 3'b000);
        push_op(32'h7F7FFFFF, 3'b000);
        run_stream("overflow_sum", 0, {3'b010, 32'h7F800000}, 0);
        push_op(32'h00800001, 3'b000);
        push_op(32'h80800000, 3'b000);
        run_stream("underflow_norm", 0, {3'b001, 32'h00000000}, 0);
        exp_q.push_back({3'b100, 32'h00000000});
        send_op(32'h3F800000, 3'b000, 1'b0);
        count_ready_low(n);
        check_int("exc_first_add", n, 4);
        send_op(32'h40000000, 3'b100, 1'b0);
        count_ready_low(n);
        check_int("exc_skip", n, 0);
        send_op(32'h3F800000, 3'b000, 1'b0);
        count_ready_low(n);
        check_int("exc_later_skip", n, 0);
        send_op(32'h3F800000, 3'b000, 1'b1);
        collect_output("exception", 0);
        push_op(32'hC0000000, 3'b010);
        push_op(32'h3F800000, 3'b000);
        run_stream("ovf_flag_in", 0, {3'b010, 32'hFF800000}, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) push_op(32'h3F800000, 3'b000);
        run_stream("backpressure", 0, {3'b000, 32'h40800000}, 3);
        push_op(32'h3F800000, 3'b000);
        run_stream("after_clear", 0, {3'b000, 32'h3F800000}, 0);
    endtask

    task automatic test_reset_mid_norm();
        int n;
        send_op(32'h3F800001, 3'b000, 1'b0);
        count_ready_low(n);
        send_op(32'hBF800000, 3'b000, 1'b1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_exception, out_overflow, out_underflow, out_data} !== 37'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h, required 0",
                     {in_ready, out_valid, out_exception, out_overflow, out_underflow, out_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_abort: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
        end
        push_op(32'h40000000, 3'b000);
        run_stream("after_mid_reset", 0, {3'b000, 32'h40000000}, 0);
    endtask

    function automatic logic [31:0] rand_op(input logic [31:0] prev);
        int sel;
        logic [7:0] e;
        sel = $urandom_range(0, 15);
        if (sel == 0) return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
        if (sel <= 2 && prev[30:23] != 8'h00) return {~prev[31], prev[30:1], ~prev[0]};
        if (sel == 3) e = 8'($urandom_range(1, 254));
        else          e = 8'($urandom_range(118, 132));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic test_random();
        logic [31:0] prev, d;
        logic [2:0]  f;
        int len;
        prev = 32'h3F800000;
        for (int s = 0; s < 30; s++) begin
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                d = rand_op(prev);
                f = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                push_op(d, f);
                prev = d;
            end
            run_stream("random_stream", 1, 35'h0, $urandom_range(0, 2));
        end
    endtask

    initial begin
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        in_exception = 0; in_overflow = 0; in_underflow = 0;
        test_reset();
        test_simple_sum();
        test_cancel();
        test_rounding();
        test_flags();
        test_back_to_back();
        test_reset_mid_norm();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential floating-point accumulator that sits directly downstream of the combinational `Multiplication` stage and sums its stream of products. It takes one product per valid/ready handshake, together with the multiplier's exception, overflow and underflow flags. It adds each product into an internal running sum using a multi-cycle align / add / normalise / round FSM. When the operand marked `in_last` has been absorbed, it presents the final sum on a valid/ready output port.

## Interface
- `frac_bits`, 23, fraction width; same meaning as the multiplier.
- `exp_bits`, 8, exponent width; bias = 2^(exp_bits-1)-1.
- W = exp_bits+frac_bits+1 throughout.
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  product word present.
- `in_ready`  out  1  block can accept a product.
- `in_data`  in  W  product, {sign, exp, frac}.
- `in_exception`, `in_overflow`, `in_underflow`  in  1 each  flags accompanying `in_data`.
- `in_last`  in  1  this product closes the current sum.
- `out_valid`  out  1  final sum available.
- `out_ready`  in  1  consumer takes the sum.
- `out_data`  out  W  accumulated sum.
- `out_exception`, `out_overflow`, `out_underflow`  out  1 each  sticky flags for the sum just completed.

## Operation
- **Data held.** Accumulator register `acc` (W bits), plus sticky flags `exc`, `ovf`, `unf`. All are cleared to +0 / 0 at reset and after each output handshake.
- **Zero encoding.** Exponent field 0 is treated as zero. Denormals are flushed to zero.
- **Internal datapath.** Mantissa is frac_bits+1 bits with a hidden one, plus a carry bit and guard, round and sticky bits.
- **IDLE.**
  - `in_ready`=1. An operand is accepted when `in_valid`&`in_ready`; latch `in_data`, the flags and `in_last`.
  - If `in_exception`, set `exc`.
  - If `in_overflow`, set `ovf` and set `acc` = {operand sign, all-ones, 0}.
  - If `in_underflow`, set `unf`.
  - The add is skipped when any of these holds: a flag is set on the operand, the operand exponent is 0, `exc`=1, or `ovf`=1. On a skip, go to OUT if last, else stay in IDLE.
  - Otherwise go to ALIGN.
- **ALIGN** (1 cycle).
  - Order the operands so the larger magnitude is A: compare exponent, then mantissa on a tie.
  - Barrel-shift B right by the exponent difference, ORing shifted-out bits into sticky.
  - A difference greater than frac_bits+3 leaves B as sticky only.
- **ADD** (1 cycle). Same signs: A+B. Different signs: A−B, which is never negative. Result sign = sign of A.
- **NORM.**
  - Carry set: shift right 1, exponent+1, one cycle.
  - Otherwise, while MSB=0 and the result is nonzero: shift left 1, exponent−1, one bit per cycle.
  - Result exactly zero: `acc`=+0, skip ROUND.
  - Exponent reaching 0: `acc`=+0, set `unf`.
- **ROUND** (1 cycle).
  - Round to nearest, ties to even, using guard/round/sticky.
  - Mantissa carry out of rounding: exponent+1.
  - Exponent reaching all-ones: `acc`={sign, all-ones, 0}, set `ovf`.
  - Write `acc`, then go to OUT if last, else IDLE.
- **OUT.**
  - `out_valid`=1. `out_data` = `acc`, except `exc`=1 forces `out_data`=0, matching the upstream convention.
  - Output data and flags are held stable while `out_ready`=0.
  - On handshake: clear `acc` and the flags, go to IDLE.
- Exponent arithmetic uses exp_bits+1 bits, so the overflow and underflow checks cannot wrap.

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n`=0, and 1 in the first cycle after release.
  - `out_valid`=0, `out_data`=0, and all out flags 0.
  - State = IDLE.
- Reset mid-operation aborts immediately and discards `acc` and the latched operand.
- Accept-to-accept spacing:
  - Skipped operand: 1 cycle.
  - Add path: 4+n cycles, where n = NORM cycles. n is 1 for carry-out or an already-normalised result, and at most frac_bits+3.
- `in_ready`=0 in ALIGN, ADD, NORM, ROUND and OUT.
- `out_valid` rises the cycle after ROUND (or after IDLE on a skipped last) and falls the cycle after the handshake.
- A new stream can be accepted the cycle after the output handshake.
- `in_last` on a skipped operand still produces an output.

## Test plan
- **Simple sum.** 3FC00000 then 40100000 (last) -> `out_data`=40700000, no flags; `in_ready` is low 4 cycles after each accept.
- **Cancellation and long normalise.**
  - 3F800000 + BF800000 (last) -> 00000000.
  - 3F800001 + BF800000 (last) -> 34000000, with NORM taking 23 cycles and `in_ready` low throughout.
- **Ties-to-even rounding.**
  - 3F800000 + 33800000 -> 3F800000.
  - 3F800001 + 33800000 -> 3F800002.
- **Flags.**
  - 7F7FFFFF + 7F7FFFFF -> 7F800000, `out_overflow`=1.
  - Any operand with `in_exception`=1 -> 00000000, `out_exception`=1; later operands are skipped in 1 cycle each.
- **Backpressure.** Four 3F800000 operands, last on the fourth, with `out_ready` low for 3 cycles -> 40800000 held stable. After the handshake, 3F800000 (last) -> 3F800000, proving the clear.
- **Reset mid-NORM.** Drop `rst_n` during the 3F800001 − 3F800000 case -> outputs go to 0 at once; the next stream starts from +0.
